// File: rtl/sdram_port_arbiter_if.sv
// Requester and SDRAM controller user-port signals around sdram_port_arbiter.
// The arbiter takes the slave view; requesters and controller take the master view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
);
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic              r_ack;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_done;

    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [DATA_W-1:0] w_data;
    logic              w_ack;
    logic              w_pop;
    logic              w_done;

    logic              sdrc_init_done;
    logic              sdrc_busy_n;
    logic              sdrc_rd_valid;
    logic [DATA_W-1:0] sdrc_data_out;
    logic              sdrc_rd_n;
    logic              sdrc_wr_n;
    logic [ADDR_W-1:0] sdrc_addr;
    logic [7:0]        sdrc_data_len;
    logic [DATA_W-1:0] sdrc_data;
    logic [1:0]        sdrc_dqm;

    logic              timeout_err;

    modport slave (
        input  r_req, r_addr, r_len,
        input  w_req, w_addr, w_len, w_data,
        input  sdrc_init_done, sdrc_busy_n,
        input  sdrc_rd_valid, sdrc_data_out,
        output r_ack, r_data, r_valid, r_done,
        output w_ack, w_pop, w_done,
        output sdrc_rd_n, sdrc_wr_n, sdrc_addr,
        output sdrc_data_len, sdrc_data, sdrc_dqm,
        output timeout_err
    );

    modport master (
        output r_req, r_addr, r_len,
        output w_req, w_addr, w_len, w_data,
        output sdrc_init_done, sdrc_busy_n,
        output sdrc_rd_valid, sdrc_data_out,
        input  r_ack, r_data, r_valid, r_done,
        input  w_ack, w_pop, w_done,
        input  sdrc_rd_n, sdrc_wr_n, sdrc_addr,
        input  sdrc_data_len, sdrc_data, sdrc_dqm,
        input  timeout_err
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port (display read / frame-buffer write) arbiter for one SDRAM
// controller user port: one burst at a time, read priority, bounded starvation.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int BUSY_MASK    = 3,
    parameter int TIMEOUT      = 1023
) (
    input  logic clk,
    input  logic reset,
    sdram_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE_RD,
        RD_DATA,
        ISSUE_WR,
        WR_DATA,
        WAIT_IDLE
    } state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [SW-1:0]     starve;
    logic [8:0]        beats;
    logic [TW-1:0]     cyc;
    logic              burst_wr;
    logic [DATA_W-1:0] wdata_q;

    logic last_beat;
    logic timed_out;
    logic idle_seen;
    logic write_turn;

    // beats is 9 bits so a 256-beat burst (len=255) never wraps
    assign last_beat  = beats == {1'b0, bus.sdrc_data_len};
    assign timed_out  = cyc == TW'(TIMEOUT - 1);
    assign idle_seen  = (cyc >= TW'(BUSY_MASK)) && bus.sdrc_busy_n;
    assign write_turn = bus.w_req &&
                        (!bus.r_req || starve == SW'(STARVE_LIMIT));

    assign bus.sdrc_data = bus.w_pop ? bus.w_data : wdata_q;
    assign bus.sdrc_dqm  = 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= INIT;
            starve            <= '0;
            beats             <= '0;
            cyc               <= '0;
            burst_wr          <= 1'b0;
            wdata_q           <= '0;
            bus.r_ack         <= 1'b0;
            bus.r_data        <= '0;
            bus.r_valid       <= 1'b0;
            bus.r_done        <= 1'b0;
            bus.w_ack         <= 1'b0;
            bus.w_pop         <= 1'b0;
            bus.w_done        <= 1'b0;
            bus.sdrc_rd_n     <= 1'b1;
            bus.sdrc_wr_n     <= 1'b1;
            bus.sdrc_addr     <= '0;
            bus.sdrc_data_len <= '0;
            bus.timeout_err   <= 1'b0;
        end else begin
            bus.r_ack     <= 1'b0;
            bus.w_ack     <= 1'b0;
            bus.r_valid   <= 1'b0;
            bus.r_done    <= 1'b0;
            bus.w_done    <= 1'b0;
            bus.sdrc_rd_n <= 1'b1;
            bus.sdrc_wr_n <= 1'b1;
            cyc           <= cyc + 1'b1;
            if (!bus.w_req) starve <= '0;
            if (bus.w_pop) wdata_q <= bus.w_data;

            unique case (state)
                INIT: begin
                    if (bus.sdrc_init_done) state <= IDLE;
                end

                IDLE: begin
                    if (bus.sdrc_busy_n && write_turn) begin
                        bus.w_ack         <= 1'b1;
                        bus.sdrc_addr     <= ADDR_W'(bus.w_addr);
                        bus.sdrc_data_len <= bus.w_len;
                        burst_wr          <= 1'b1;
                        starve            <= '0;
                        state             <= ISSUE_WR;
                    end else if (bus.sdrc_busy_n && bus.r_req) begin
                        bus.r_ack         <= 1'b1;
                        bus.sdrc_addr     <= ADDR_W'(bus.r_addr);
                        bus.sdrc_data_len <= bus.r_len;
                        burst_wr          <= 1'b0;
                        if (bus.w_req) starve <= starve + 1'b1;
                        state             <= ISSUE_RD;
                    end
                end

                ISSUE_RD: begin
                    bus.sdrc_rd_n <= 1'b0;
                    cyc           <= '0;
                    beats         <= '0;
                    state         <= RD_DATA;
                end

                RD_DATA: begin
                    if (bus.sdrc_rd_valid) begin
                        bus.r_data  <= bus.sdrc_data_out;
                        bus.r_valid <= 1'b1;
                        beats       <= beats + 1'b1;
                    end
                    if (bus.sdrc_rd_valid && last_beat) begin
                        state <= WAIT_IDLE;
                    end else if (timed_out) begin
                        // remaining beats are dropped; later rd_valid is ignored
                        bus.timeout_err <= 1'b1;
                        bus.r_done      <= 1'b1;
                        state           <= IDLE;
                    end
                end

                ISSUE_WR: begin
                    bus.sdrc_wr_n <= 1'b0;
                    bus.w_pop     <= 1'b1;
                    cyc           <= '0;
                    beats         <= '0;
                    state         <= WR_DATA;
                end

                WR_DATA: begin
                    if (last_beat) begin
                        bus.w_pop <= 1'b0;
                        state     <= WAIT_IDLE;
                    end else if (timed_out) begin
                        bus.w_pop       <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        bus.w_done      <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        beats <= beats + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (idle_seen) begin
                        bus.r_done <= !burst_wr;
                        bus.w_done <= burst_wr;
                        state      <= IDLE;
                    end else if (timed_out) begin
                        bus.timeout_err <= 1'b1;
                        bus.r_done      <= !burst_wr;
                        bus.w_done      <= burst_wr;
                        state           <= IDLE;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end
endmodule
